sync_updown_counter: RTL and testbench

Parametrised synchronous up/down counter with programmable modulus, parallel load, enable, and wrap-or-stop end behaviour. It replaces the fixed 3-bit negedge ripple chain with a single-clock design. All bits change on the same `clk` edge, so no intermediate glitch states are visible. A combinational terminal-count output lets instances cascade synchronously into wider or multi-stage counters.

---
 rtl/counter_pkg.sv | 16 +
 rtl/sync_updown_counter_if.sv | 31 +++
 rtl/cnt_next.sv | 30 +++
 rtl/sync_updown_counter.sv | 76 +++++++
 tb/tb_sync_updown_counter.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
// Package : counter_pkg -- shared state encoding and limits for the counter
// Rev     : 1.0
// ============================================================================
package counter_pkg;

    localparam int MAX_WIDTH = 32;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

endpackage : counter_pkg
`default_nettype wire

// File: rtl/sync_updown_counter_if.sv
`default_nettype none
// ============================================================================
// Interface : sync_updown_counter_if -- control/status bundle of the counter
// Rev       : 1.0
// ============================================================================
interface sync_updown_counter_if #(
    parameter int WIDTH = 3
) ();

    logic             en;
    logic             up;
    logic             stop_mode;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrap;
    logic             done;

    modport master (
        output en, up, stop_mode, load, load_val,
        input  count, tc, wrap, done
    );

    modport slave (
        input  en, up, stop_mode, load, load_val,
        output count, tc, wrap, done
    );

endinterface : sync_updown_counter_if
`default_nettype wire

// File: rtl/cnt_next.sv
`default_nettype none
// ============================================================================
// Module : cnt_next -- combinational stepped value and end-of-range detector
// Rev    : 1.0
// ============================================================================
module cnt_next #(
    parameter int               WIDTH = 3,
    parameter logic [WIDTH-1:0] LAST  = '1
) (
    input  wire logic [WIDTH-1:0] count,
    input  wire logic             up,
    output logic      [WIDTH-1:0] next,
    output logic                  at_end
);

    // The end value already implies the wrap target, so the step never leaves 0..LAST.
    always_comb begin
        next   = count;
        at_end = 1'b0;
        if (up) begin
            at_end = (count == LAST);
            next   = at_end ? '0 : count + WIDTH'(1);
        end else begin
            at_end = (count == '0);
            next   = at_end ? LAST : count - WIDTH'(1);
        end
    end

endmodule : cnt_next
`default_nettype wire

// File: rtl/sync_updown_counter.sv
`default_nettype none
// ============================================================================
// Module : sync_updown_counter -- modulus up/down counter, load, wrap or stop
// Rev    : 1.0
// ============================================================================
module sync_updown_counter
    import counter_pkg::*;
#(
    parameter int     WIDTH   = 3,
    parameter longint MODULUS = 8
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    sync_updown_counter_if.slave      bus
);

    localparam logic [WIDTH-1:0] c_last = WIDTH'(MODULUS - 64'sd1);

    if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("sync_updown_counter: WIDTH out of range 1..32");
    end

    if (MODULUS < 64'sd2 || MODULUS > (64'sd1 << WIDTH)) begin : g_bad_modulus
        $error("sync_updown_counter: MODULUS out of range 2..2**WIDTH");
    end

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic             r_done;
    state_t           r_state;
    logic [WIDTH-1:0] w_next;
    logic             w_at_end;

    cnt_next #(
        .WIDTH (WIDTH),
        .LAST  (c_last)
    ) u_cnt_next (
        .count  (r_count),
        .up     (bus.up),
        .next   (w_next),
        .at_end (w_at_end)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
            r_done  <= 1'b0;
            r_state <= ST_RUN;
        end else if (bus.load) begin
            r_count <= (bus.load_val > c_last) ? c_last : bus.load_val;
            r_wrap  <= 1'b0;
            r_done  <= 1'b0;
            r_state <= ST_RUN;
        end else begin
            r_wrap <= 1'b0;
            if (r_state == ST_RUN && bus.en) begin
                // Stop mode freezes on the end value instead of taking the wrap step.
                if (w_at_end && bus.stop_mode) begin
                    r_state <= ST_HALT;
                    r_done  <= 1'b1;
                end else begin
                    r_count <= w_next;
                    r_wrap  <= w_at_end;
                end
            end
        end
    end

    assign bus.count = r_count;
    assign bus.wrap  = r_wrap;
    assign bus.done  = r_done;
    assign bus.tc    = bus.en & (r_state == ST_RUN) & w_at_end;

endmodule : sync_updown_counter
`default_nettype wire

// File: tb/tb_sync_updown_counter.sv
`default_nettype none
// ============================================================================
// Module : tb_sync_updown_counter -- directed vectors for the up/down counter
// Rev    : 1.0
// ============================================================================
module tb_sync_updown_counter;

    logic clk = 1'b0;
    logic rst_a, rst_c, rst_bcd;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    sync_updown_counter_if #(.WIDTH(3)) bus_a ();
    sync_updown_counter_if #(.WIDTH(2)) bus_c ();
    sync_updown_counter_if #(.WIDTH(4)) bus_lo ();
    sync_updown_counter_if #(.WIDTH(4)) bus_hi ();

    sync_updown_counter #(.WIDTH(3), .MODULUS(6))  u_a  (.clk(clk), .rst(rst_a),   .bus(bus_a));
    sync_updown_counter #(.WIDTH(2), .MODULUS(4))  u_c  (.clk(clk), .rst(rst_c),   .bus(bus_c));
    sync_updown_counter #(.WIDTH(4), .MODULUS(10)) u_lo (.clk(clk), .rst(rst_bcd), .bus(bus_lo));
    sync_updown_counter #(.WIDTH(4), .MODULUS(10)) u_hi (.clk(clk), .rst(rst_bcd), .bus(bus_hi));

    assign bus_hi.en = bus_lo.tc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       rst, en, up, sm, ld;
        logic [2:0] lv;
        logic [2:0] c;
        logic       w, d, t;
    } vec_t;

    vec_t v[$];

    initial begin
        rst_a = 1'b1; rst_c = 1'b1; rst_bcd = 1'b1;
        bus_a.en = 0; bus_a.up = 1; bus_a.stop_mode = 0; bus_a.load = 0; bus_a.load_val = '0;
        bus_c.en = 0; bus_c.up = 1; bus_c.stop_mode = 0; bus_c.load = 0; bus_c.load_val = '0;
        bus_lo.en = 0; bus_lo.up = 1; bus_lo.stop_mode = 0; bus_lo.load = 0; bus_lo.load_val = '0;
        bus_hi.up = 1; bus_hi.stop_mode = 0; bus_hi.load = 0; bus_hi.load_val = '0;

        //             rst en up sm ld lv   count wrap done tc(before edge)
        v.push_back('{0, 1, 1, 0, 0, 0,   1, 0, 0, 0});
        v.push_back('{0, 1, 1, 0, 0, 0,   2, 0, 0, 0});
        v.push_back('{0, 1, 1, 0, 0, 0,   3, 0, 0, 0});
        v.push_back('{0, 1, 1, 0, 0, 0,   4, 0, 0, 0});
        v.push_back('{0, 1, 1, 0, 0, 0,   5, 0, 0, 0});
        v.push_back('{0, 1, 1, 0, 0, 0,   0, 1, 0, 1});
        v.push_back('{0, 1, 1, 0, 0, 0,   1, 0, 0, 0});
        v.push_back('{0, 0, 1, 0, 0, 0,   1, 0, 0, 0});
        v.push_back('{0, 0, 1, 0, 1, 7,   5, 0, 0, 0});
        v.push_back('{0, 1, 0, 0, 0, 0,   4, 0, 0, 0});
        v.push_back('{0, 1, 0, 0, 0, 0,   3, 0, 0, 0});
        v.push_back('{0, 1, 0, 0, 0, 0,   2, 0, 0, 0});
        v.push_back('{0, 1, 0, 0, 0, 0,   1, 0, 0, 0});
        v.push_back('{0, 1, 0, 0, 0, 0,   0, 0, 0, 0});
        v.push_back('{0, 1, 0, 0, 0, 0,   5, 1, 0, 1});
        v.push_back('{0, 0, 0, 0, 1, 3,   3, 0, 0, 0});
        v.push_back('{0, 1, 1, 1, 0, 0,   4, 0, 0, 0});
        v.push_back('{0, 1, 1, 1, 0, 0,   5, 0, 0, 0});
        v.push_back('{0, 1, 1, 1, 0, 0,   5, 0, 1, 1});
        v.push_back('{0, 1, 0, 1, 0, 0,   5, 0, 1, 0});
        v.push_back('{0, 1, 1, 0, 0, 0,   5, 0, 1, 0});
        v.push_back('{0, 1, 1, 0, 1, 2,   2, 0, 0, 0});
        v.push_back('{0, 1, 1, 0, 1, 1,   1, 0, 0, 0});
        v.push_back('{1, 1, 1, 0, 1, 4,   0, 0, 0, 0});
        v.push_back('{0, 1, 0, 1, 0, 0,   0, 0, 1, 1});
        v.push_back('{1, 1, 0, 1, 0, 0,   0, 0, 0, 0});
        v.push_back('{0, 1, 1, 0, 0, 0,   1, 0, 0, 0});
        v.push_back('{0, 1, 0, 0, 0, 0,   0, 0, 0, 0});
        v.push_back('{0, 1, 0, 0, 0, 0,   5, 1, 0, 1});
        v.push_back('{0, 1, 1, 0, 0, 0,   0, 1, 0, 1});
        v.push_back('{0, 0, 1, 0, 1, 0,   0, 0, 0, 0});
        v.push_back('{0, 0, 1, 0, 1, 6,   5, 0, 0, 0});
        v.push_back('{0, 1, 1, 0, 1, 5,   5, 0, 0, 1});

        repeat (2) @(posedge clk);
        #1;
        rst_a = 0; rst_c = 0; rst_bcd = 0;
        check("reset_count", 32'(bus_a.count), 32'd0);
        check("reset_wrap",  32'(bus_a.wrap),  32'd0);
        check("reset_done",  32'(bus_a.done),  32'd0);

        for (int i = 0; i < v.size(); i++) begin
            rst_a          = v[i].rst;
            bus_a.en        = v[i].en;
            bus_a.up        = v[i].up;
            bus_a.stop_mode = v[i].sm;
            bus_a.load      = v[i].ld;
            bus_a.load_val  = v[i].lv;
            #1;
            check($sformatf("vec%0d_tc", i), 32'(bus_a.tc), 32'(v[i].t));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_count", i), 32'(bus_a.count), 32'(v[i].c));
            check($sformatf("vec%0d_wrap", i),  32'(bus_a.wrap),  32'(v[i].w));
            check($sformatf("vec%0d_done", i),  32'(bus_a.done),  32'(v[i].d));
        end
        rst_a = 0; bus_a.en = 0; bus_a.load = 0;

        // Full binary range: natural overflow must match the wrap rule.
        bus_c.en = 1;
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("full_count%0d", i), 32'(bus_c.count), 32'(i % 4));
            check($sformatf("full_wrap%0d", i),  32'(bus_c.wrap),  32'(i == 4));
        end
        @(posedge clk);
        #1;
        check("full_mid", 32'(bus_c.count), 32'd2);
        rst_c = 1;
        @(posedge clk);
        #1;
        rst_c = 0;
        check("full_rst", 32'(bus_c.count), 32'd0);
        bus_c.en = 0; bus_c.load = 1; bus_c.load_val = 2'd3;
        @(posedge clk);
        #1;
        bus_c.load = 0;
        check("full_load3", 32'(bus_c.count), 32'd3);

        // BCD cascade: upper stage steps only on the lower stage's terminal count.
        bus_lo.en = 1;
        repeat (10) @(posedge clk);
        #1;
        check("bcd10_lo", 32'(bus_lo.count), 32'd0);
        check("bcd10_hi", 32'(bus_hi.count), 32'd1);
        check("bcd10_lo_wrap", 32'(bus_lo.wrap), 32'd1);
        check("bcd10_hi_wrap", 32'(bus_hi.wrap), 32'd0);
        repeat (89) @(posedge clk);
        #1;
        check("bcd99_lo", 32'(bus_lo.count), 32'd9);
        check("bcd99_hi", 32'(bus_hi.count), 32'd9);
        check("bcd99_hi_tc", 32'(bus_hi.tc), 32'd1);
        @(posedge clk);
        #1;
        check("bcd100_lo", 32'(bus_lo.count), 32'd0);
        check("bcd100_hi", 32'(bus_hi.count), 32'd0);
        check("bcd100_lo_wrap", 32'(bus_lo.wrap), 32'd1);
        check("bcd100_hi_wrap", 32'(bus_hi.wrap), 32'd1);
        bus_lo.en = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_sync_updown_counter
`default_nettype wire
